// File: rtl/mod_mul_il_core.sv
// -----------------------------------------------------------------------------
// mod_mul_il_core
//   Interleaved modular multiplier: result = (a*b) mod m. The multiplier a is
//   consumed PBITS bits per cycle, most significant digit first. The upstream
//   mxn_calc stage supplies two tables derived from m and b:
//     mxn[k] = k*m           for k = 1..MLSIZE
//     bxn[d] = (d*b) mod m   for d = 0..MLSIZE-1
//
// Ports
//   clk       in   1                      rising-edge clock
//   rst_n     in   1                      asynchronous active-low reset
//   start     in   1                      request, accepted only while idle
//   a         in   NBITS                  multiplier, latched on accepted start
//   enable_p  out  1                      launch pulse to mxn_calc (combinational)
//   mxn_done  in   1                      tables-ready pulse from mxn_calc
//   mxn       in   NBITS+PBITS x [1:MLSIZE]  multiples of m
//   bxn       in   NBITS x [0:MLSIZE-1]      reduced multiples of b
//   busy      out  1                      operation in progress
//   done      out  1                      one-cycle pulse, result valid
//   result    out  NBITS                  (a*b) mod m, held until next done
// -----------------------------------------------------------------------------
module mod_mul_il_core #(
   parameter  int NBITS  = 4096,
   parameter  int PBITS  = 1,
   localparam int MLSIZE = 1 << PBITS,
   localparam int NDIG   = NBITS / PBITS
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [NBITS-1:0]       a,
   output logic                   enable_p,
   input  logic                   mxn_done,
   input  logic [NBITS+PBITS-1:0] mxn [1:MLSIZE],
   input  logic [NBITS-1:0]       bxn [0:MLSIZE-1],
   output logic                   busy,
   output logic                   done,
   output logic [NBITS-1:0]       result
);

   localparam int TW = NBITS + PBITS + 1;              // width of the partial sum t
   localparam int KW = $clog2(MLSIZE + 1);             // holds 0..MLSIZE
   localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;  // digit counter width

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_WAIT_TBL = 2'b01,
      S_RUN      = 2'b10
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [NBITS-1:0]   r_acc;
   logic [NBITS-1:0]   r_a;
   logic [DW-1:0]      r_dcnt;
   logic [NBITS-1:0]   r_result;
   logic               r_done;

   logic [PBITS-1:0]   w_digit;
   logic [TW-1:0]      w_t;
   logic [KW-1:0]      w_k;
   logic [NBITS-1:0]   w_acc_nxt;
   logic               w_last;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode plus enable_p / busy
   always_comb begin
      w_state_nxt = r_state;
      enable_p    = 1'b0;
      busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               enable_p    = 1'b1;
               w_state_nxt = S_WAIT_TBL;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT_TBL: begin
            busy = 1'b1;
            if (mxn_done) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_WAIT_TBL;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_last = (r_dcnt == DW'(0));

   // r_a is shifted left once per digit, so the current digit is always its
   // top PBITS bits.
   assign w_digit = r_a[NBITS-1 -: PBITS];

   // One interleaved step: t = acc*2^PBITS + (d*b mod m), then subtract the
   // largest multiple k*m not exceeding t. Since t < (MLSIZE+1)*m, the
   // remainder is below m, and its low NBITS bits equal the exact difference.
   always_comb begin
      w_t = {1'b0, r_acc, {PBITS{1'b0}}} + {{(PBITS+1){1'b0}}, bxn[w_digit]};
      w_k = KW'(0);
      for (int j = 1; j <= MLSIZE; j++) begin
         if ({1'b0, mxn[j]} <= w_t) begin
            w_k = w_k + KW'(1);
         end else begin
            w_k = w_k;
         end
      end
      w_acc_nxt = w_t[NBITS-1:0];
      for (int j = 1; j <= MLSIZE; j++) begin
         if (w_k == KW'(j)) begin
            w_acc_nxt = w_t[NBITS-1:0] - mxn[j][NBITS-1:0];
         end else begin
            w_acc_nxt = w_acc_nxt;
         end
      end
   end

   // Datapath registers: operand latch, accumulator, digit counter, result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_a      <= '0;
         r_dcnt   <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a    <= a;
                  r_acc  <= '0;
                  r_dcnt <= DW'(NDIG - 1);
               end
            end
            S_RUN: begin
               r_acc <= w_acc_nxt;
               r_a   <= r_a << PBITS;
               if (w_last) begin
                  r_result <= w_acc_nxt;
               end else begin
                  r_dcnt <= r_dcnt - DW'(1);
               end
            end
            default: begin
               r_acc <= r_acc;
            end
         endcase
      end
   end

   // done pulses in the first idle cycle after the last digit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == S_RUN) && w_last;
      end
   end

   assign done   = r_done;
   assign result = r_result;

endmodule

// File: tb/tb_mod_mul_il_core.sv
module tb_mod_mul_il_core;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a_in;
   int         m_val;
   int         b_val;

   // radix-4 instance (NBITS=8, PBITS=2)
   logic       start, enable_p, mxn_done, busy, done;
   logic [7:0] result;
   logic [9:0] mxn0 [1:4];
   logic [7:0] bxn0 [0:3];

   // radix-2 instance (NBITS=8, PBITS=1)
   logic       start1, enable_p1, mxn_done1, busy1, done1;
   logic [7:0] result1;
   logic [8:0] mxn1 [1:2];
   logic [7:0] bxn1 [0:1];

   int n_tests = 0;
   int n_fail  = 0;
   int sb_q[$];
   int tcnt0, tcnt1;

   always #5 clk = ~clk;

   mod_mul_il_core #(.NBITS(8), .PBITS(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a_in), .enable_p(enable_p),
      .mxn_done(mxn_done), .mxn(mxn0), .bxn(bxn0), .busy(busy), .done(done),
      .result(result));

   mod_mul_il_core #(.NBITS(8), .PBITS(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a_in), .enable_p(enable_p1),
      .mxn_done(mxn_done1), .mxn(mxn1), .bxn(bxn1), .busy(busy1), .done(done1),
      .result(result1));

   // Table contents an ideal mxn_calc would present for the current m and b
   always_comb begin
      for (int k = 1; k <= 4; k++) mxn0[k] = 10'(k * m_val);
      for (int d = 0; d < 4; d++)  bxn0[d] = 8'((d * b_val) % m_val);
      for (int k = 1; k <= 2; k++) mxn1[k] = 9'(k * m_val);
      for (int d = 0; d < 2; d++)  bxn1[d] = 8'((d * b_val) % m_val);
   end

   // mxn_calc timing model: tables ready MLSIZE-1 cycles after launch
   // (at least one cycle, so the pulse lands in the table-wait state)
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt0 <= 0;
         tcnt1 <= 0;
      end else begin
         if (enable_p) tcnt0 <= 3;
         else if (tcnt0 != 0) tcnt0 <= tcnt0 - 1;
         if (enable_p1) tcnt1 <= 1;
         else if (tcnt1 != 0) tcnt1 <= tcnt1 - 1;
      end
   end
   assign mxn_done  = (tcnt0 == 1);
   assign mxn_done1 = (tcnt1 == 1);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive a request at the current negedge (cycle 0) and queue its expected result
   task automatic issue(input bit sel, input int av, input int bv, input int mv);
      a_in  = 8'(av);
      b_val = bv;
      m_val = mv;
      sb_q.push_back((av * bv) % mv);
      if (sel) start1 = 1'b1;
      else     start  = 1'b1;
      #1;
      chk("enable_p_on_start", sel ? enable_p1 : enable_p, 1);
   endtask

   // Wait (bounded) for done; optionally re-pulse start at cycle 'poke'
   task automatic run_wait(input bit sel, input int exp_lat, input int poke);
      int cyc;
      bit seen;
      int e;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start  = 1'b0;
            start1 = 1'b0;
         end
         if (cyc == poke) begin
            start = 1'b1;
            #1;
            chk("enable_p_during_run", enable_p, 0);
            chk("busy_during_run", busy, 1);
         end else if (cyc == poke + 1) begin
            start = 1'b0;
         end
         if (sel ? done1 : done) seen = 1'b1;
      end
      chk("done_seen", seen, 1);
      if (seen) begin
         chk("latency", cyc, exp_lat);
         e = (sb_q.size() > 0) ? sb_q.pop_front() : -1;
         chk("result", sel ? result1 : result, e);
      end
   endtask

   initial begin
      int extra;
      int ra, rb, rm;
      rst_n  = 1'b0;
      start  = 1'b0;
      start1 = 1'b0;
      a_in   = 8'd0;
      m_val  = 1;
      b_val  = 0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_enable_p", enable_p, 0);
      chk("rst_result1", result1, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // directed operands
      issue(0, 200, 100, 239); run_wait(0, 8, -1); @(negedge clk);
      issue(0, 255, 238, 239); run_wait(0, 8, -1); @(negedge clk);
      issue(0, 0, 5, 7);       run_wait(0, 8, -1); @(negedge clk);
      issue(0, 255, 0, 1);     run_wait(0, 8, -1); @(negedge clk);

      // back-to-back: second start on the done cycle
      issue(0, 77, 50, 101);   run_wait(0, 8, -1);
      issue(0, 13, 200, 251);
      chk("result_hold_on_done_cycle", result, (77 * 50) % 101);
      run_wait(0, 8, -1);

      // start re-pulsed in RUN must be ignored
      @(negedge clk);
      issue(0, 123, 45, 67);   run_wait(0, 8, 5);
      extra = 0;
      repeat (14) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk("no_extra_done", extra, 0);
      chk("result_after_ignored_start", result, (123 * 45) % 67);

      // reset mid-RUN aborts the operation
      issue(0, 200, 100, 239);
      repeat (5) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_result", result, 0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(0, 211, 99, 233);  run_wait(0, 8, -1);

      // random operands, b < m
      for (int i = 0; i < 6; i++) begin
         rm = int'($urandom_range(255, 1));
         rb = int'($urandom_range(rm - 1, 0));
         ra = int'($urandom_range(255, 0));
         @(negedge clk);
         issue(0, ra, rb, rm);
         run_wait(0, 8, -1);
      end

      // radix-2 instance: done NDIG+1 cycles after mxn_done (mxn_done in cycle 1)
      @(negedge clk);
      issue(1, 200, 100, 239); run_wait(1, 1 + 8 + 1, -1);
      for (int i = 0; i < 3; i++) begin
         rm = int'($urandom_range(255, 1));
         rb = int'($urandom_range(rm - 1, 0));
         ra = int'($urandom_range(255, 0));
         @(negedge clk);
         issue(1, ra, rb, rm);
         run_wait(1, 10, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
